// File: rtl/game_pkg.sv
// Shared types and defaults for the game's input conditioning logic.
// Default timings assume the 50 MHz board clock.
package game_pkg;

    typedef enum logic [1:0] {
        KC_IDLE,
        KC_PRESSED,
        KC_LONG
    } kc_state_t;

    localparam int KC_DEBOUNCE_DEFAULT = 500_000;     // 10 ms
    localparam int KC_HOLD_DEFAULT     = 50_000_000;  // 1 s

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs (keys, switches).
// Two-cycle latency; the flops load RST_VAL while rst is high.
module sync2 #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounces one active-low push-button and emits press/release/tap/long_press pulses.
// Level and press/release follow the pin by 2 sync cycles plus DEBOUNCE_CYCLES; all outputs registered.
module key_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEFAULT,
    parameter int HOLD_CYCLES     = KC_HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic tap_o,
    output logic long_press_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("key_conditioner: HOLD_CYCLES must be >= 2");
    end

    logic key_sync;
    logic s;

    sync2 #(.W(1), .RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (key_n_i),
        .q_o (key_sync)
    );

    assign s = ~key_sync;

    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          level_q, level_d;
    logic          rise, fall;

    // Any cycle where the input agrees with level restarts the count.
    always_comb begin
        dcnt_d  = '0;
        level_d = level_q;
        if (s != level_q) begin
            if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    kc_state_t     state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          press_d, release_d, tap_d, long_d;

    // Edges are taken from level_d so pulses line up with the registered level.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        tap_d     = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            KC_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    hcnt_d  = '0;
                    state_d = KC_PRESSED;
                end
            end
            KC_PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    tap_d     = 1'b1;
                    state_d   = KC_IDLE;
                end else if (hcnt_q == HW'(HOLD_CYCLES - 1)) begin
                    long_d  = 1'b1;
                    state_d = KC_LONG;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            KC_LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = KC_IDLE;
                end
            end
            default: state_d = KC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q       <= '0;
            level_q      <= 1'b0;
            state_q      <= KC_IDLE;
            hcnt_q       <= '0;
            press_o      <= 1'b0;
            release_o    <= 1'b0;
            tap_o        <= 1'b0;
            long_press_o <= 1'b0;
        end else begin
            dcnt_q       <= dcnt_d;
            level_q      <= level_d;
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            press_o      <= press_d;
            release_o    <= release_d;
            tap_o        <= tap_d;
            long_press_o <= long_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboarded bench for key_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
// Expected pulses are queued as (edge index, event bits) and matched by a negedge monitor.
module tb_key_conditioner;

    localparam logic [3:0] EV_PRESS = 4'b1000;
    localparam logic [3:0] EV_REL   = 4'b0100;
    localparam logic [3:0] EV_TAP   = 4'b0010;
    localparam logic [3:0] EV_LONG  = 4'b0001;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic key_n = 1'b1;
    logic level, press, rel, tap, long_press;

    key_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_n_i      (key_n),
        .level_o      (level),
        .press_o      (press),
        .release_o    (rel),
        .tap_o        (tap),
        .long_press_o (long_press)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] ev;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int at, input logic [3:0] ev);
        exp_t e;
        e.at = at;
        e.ev = ev;
        sb.push_back(e);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic [3:0] ev;
        exp_t       e;
        ev = {press, rel, tap, long_press};
        if (ev != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'(ev), 0);
            end else begin
                e = sb.pop_front();
                check("event_edge", cyc, e.at);
                check("event_bits", int'(ev), int'(e.ev));
            end
        end
    end

    initial begin
        int c;

        // reset state
        wait_edges(3);
        check("rst_level", int'(level), 0);
        check("rst_pulses", int'({press, rel, tap, long_press}), 0);
        rst = 1'b0;
        wait_edges(2);

        // 1: clean press and release
        c = cyc;
        key_n = 1'b0;
        push(c + 6, EV_PRESS);
        wait_edges(7);
        check("t1_level_high", int'(level), 1);
        wait_edges(3);
        key_n = 1'b1;
        push(cyc + 6, EV_REL | EV_TAP);
        wait_edges(8);
        check("t1_level_low", int'(level), 0);

        // 2: bounce, never stable long enough
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_edges(2);
        end
        key_n = 1'b1;
        wait_edges(8);
        check("t2_level", int'(level), 0);

        // 3: long press
        c = cyc;
        key_n = 1'b0;
        push(c + 6, EV_PRESS);
        push(c + 26, EV_LONG);
        wait_edges(30);
        check("t3_level", int'(level), 1);
        wait_edges(10);
        key_n = 1'b1;
        push(cyc + 6, EV_REL);
        wait_edges(10);

        // 4: level falls on the same edge the hold threshold is reached
        c = cyc;
        key_n = 1'b0;
        push(c + 6, EV_PRESS);
        wait_edges(20);
        key_n = 1'b1;
        push(c + 26, EV_REL | EV_TAP);
        wait_edges(10);

        // 5: reset mid-press, key still held
        c = cyc;
        key_n = 1'b0;
        push(c + 6, EV_PRESS);
        wait_edges(10);
        rst = 1'b1;
        wait_edges(1);
        check("t5_rst_level", int'(level), 0);
        check("t5_rst_pulses", int'({press, rel, tap, long_press}), 0);
        rst = 1'b0;
        push(cyc + 6, EV_PRESS);
        wait_edges(9);
        key_n = 1'b1;
        push(cyc + 6, EV_REL | EV_TAP);
        wait_edges(10);

        // 6: one-cycle glitch after 3 low cycles restarts the debounce
        c = cyc;
        key_n = 1'b0;
        wait_edges(3);
        key_n = 1'b1;
        wait_edges(1);
        key_n = 1'b0;
        push(c + 10, EV_PRESS);
        wait_edges(4);
        check("t6_level_delayed", int'(level), 0);
        wait_edges(4);
        check("t6_level_high", int'(level), 1);
        key_n = 1'b1;
        push(cyc + 6, EV_REL | EV_TAP);
        wait_edges(10);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
